// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC column-array sequencer: FSM state encoding,
// array instruction encodings and the key-load phase length.
package mac_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // Key capture runs two cycles longer than the column count.
    function automatic int load_len_f(input int c);
        return c + 2;
    endfunction

endpackage

// File: rtl/mac_seq_issue.sv
// SRAM read issue path: address counter plus the one-cycle instruction delay
// that aligns inst with the data returned by the 1-cycle-latency SRAM.
module mac_seq_issue
    import mac_seq_ctrl_pkg::*;
#(
    parameter int addr_w = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              issue_i,
    input  logic              kind_i,
    output logic              mem_cen_o,
    output logic [addr_w-1:0] mem_addr_o,
    output logic [1:0]        inst_o
);

    logic [addr_w-1:0] addr_q, addr_d;
    logic [1:0]        inst_q, inst_d;

    always_comb begin
        addr_d = addr_q;
        inst_d = INST_NOP;
        if (clr_i) begin
            addr_d = '0;
        end else if (issue_i) begin
            addr_d = addr_q + addr_w'(1);
        end
        if (issue_i) begin
            inst_d = kind_i ? INST_EXEC : INST_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            inst_q <= INST_NOP;
        end else begin
            addr_q <= addr_d;
            inst_q <= inst_d;
        end
    end

    assign mem_cen_o  = ~issue_i;
    assign mem_addr_o = addr_q;
    assign inst_o     = inst_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Pass sequencer for the MAC column array: key load, gap, query execute with
// output-FIFO backpressure, drain, done. MAC_SEQ_PERF_EN adds the stall counter.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int col    = 8,
    parameter int num_q  = 8,
    parameter int addr_w = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_full,
    output logic              mem_cen,
    output logic              mem_sel,
    output logic [addr_w-1:0] mem_addr,
    output logic [1:0]        inst,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_cnt
);

    localparam int LOAD_LEN = load_len_f(col);
    localparam int DRN_W    = $clog2(col + 1) + 1;

    state_t             state_q, state_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               issue, kind, clr;

    always_comb begin
        state_d = state_q;
        drn_d   = drn_q;
        issue   = 1'b0;
        kind    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                issue = 1'b1;
                if (mem_addr == addr_w'(LOAD_LEN - 1)) state_d = ST_GAP;
            end
            ST_GAP: begin
                clr     = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                kind  = 1'b1;
                drn_d = '0;
                if (!ofifo_full) begin
                    issue = 1'b1;
                    if (mem_addr == addr_w'(num_q - 1)) state_d = ST_DRAIN;
                end
            end
            // Done lands col+2 cycles after the final query issue.
            ST_DRAIN: begin
                drn_d = drn_q + DRN_W'(1);
                if (drn_q == DRN_W'(col)) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
        end
    end

    mac_seq_issue #(
        .addr_w (addr_w)
    ) u_issue (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (clr),
        .issue_i    (issue),
        .kind_i     (kind),
        .mem_cen_o  (mem_cen),
        .mem_addr_o (mem_addr),
        .inst_o     (inst)
    );

    assign mem_sel = kind;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FIN);

`ifdef MAC_SEQ_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == ST_EXEC && ofifo_full && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: directed passes push timed expectations,
// a negedge monitor pops and compares reads, instructions and done pulses.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_full;
    logic        mem_cen, mem_sel, busy, done;
    logic [4:0]  mem_addr;
    logic [1:0]  inst;
    logic [15:0] stall_cnt;

    mac_seq_ctrl #(.col(8), .num_q(8), .addr_w(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ofifo_full (ofifo_full),
        .mem_cen    (mem_cen),
        .mem_sel    (mem_sel),
        .mem_addr   (mem_addr),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int v;
    } ev_t;

    ev_t rdq[$];
    ev_t instq[$];
    ev_t doneq[$];
    ev_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MAC_SEQ_PERF_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Cycle c is the interval following the c-th rising edge.
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected events for a pass whose start is high in cycle k; queries at or
    // beyond index sq are delayed sl cycles by backpressure.
    task automatic push_pass(input int k, input int sq, input int sl,
                             input int nrd, input int ninst, input bit dn);
        int t;
        int tlast;
        tlast = 0;
        for (int i = 0; i < 10; i++) begin
            rdq.push_back('{k + 1 + i, i});
            instq.push_back('{k + 2 + i, 1});
        end
        for (int q = 0; q < 8; q++) begin
            t = k + 12 + q + ((q >= sq) ? sl : 0);
            if (q < nrd)   rdq.push_back('{t, 32 + q});
            if (q < ninst) instq.push_back('{t + 1, 2});
            tlast = t;
        end
        if (dn) doneq.push_back('{tlast + 10, 1});
    endtask

    always @(negedge clk) begin
        if (mem_cen !== 1'b1) begin
            chk("rd_pending", int'(rdq.size() != 0), 1);
            if (rdq.size() != 0) begin
                mon_e = rdq.pop_front();
                chk("rd_cycle", cyc, mon_e.c);
                chk("rd_sel_addr", int'({mem_sel, mem_addr}), mon_e.v);
            end
        end
        if (inst !== 2'b00) begin
            chk("inst_pending", int'(instq.size() != 0), 1);
            if (instq.size() != 0) begin
                mon_e = instq.pop_front();
                chk("inst_cycle", cyc, mon_e.c);
                chk("inst_val", int'(inst), mon_e.v);
            end
        end
        if (done !== 1'b0) begin
            chk("done_pending", int'(doneq.size() != 0), 1);
            if (doneq.size() != 0) begin
                mon_e = doneq.pop_front();
                chk("done_cycle", cyc, mon_e.c);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        ofifo_full = 1'b0;
        @(posedge clk);
        #1;
        wait_to(2);
        chk("rst_mem_cen", int'(mem_cen), 1);
        chk("rst_mem_sel", int'(mem_sel), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_inst", int'(inst), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        reset = 1'b0;

        // Plain pass
        wait_to(4);
        push_pass(4, 100, 0, 8, 8, 1'b1);
        start = 1'b1;
        wait_to(5);
        start = 1'b0;
        chk("busy_in_pass", int'(busy), 1);
        wait_to(34);
        chk("busy_after_done", int'(busy), 0);
        chk("stall_plain", int'(stall_cnt), 0);

        // Backpressure for three cycles at query 3
        wait_to(40);
        push_pass(40, 3, 3, 8, 8, 1'b1);
        start = 1'b1;
        wait_to(41);
        start = 1'b0;
        wait_to(55);
        ofifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_to(55 + i);
            #1;
            chk("stall_mem_cen", int'(mem_cen), 1);
            chk("stall_mem_addr", int'(mem_addr), 3);
        end
        wait_to(58);
        ofifo_full = 1'b0;
        wait_to(75);
        chk("stall_cnt_bp", int'(stall_cnt), EXP_STALL);

        // ofifo_full through the whole load phase
        wait_to(80);
        push_pass(80, 100, 0, 8, 8, 1'b1);
        start      = 1'b1;
        ofifo_full = 1'b1;
        wait_to(81);
        start = 1'b0;
        wait_to(91);
        ofifo_full = 1'b0;
        wait_to(112);
        chk("stall_cnt_load_full", int'(stall_cnt), 0);

        // Reset while query 5 is being issued
        wait_to(120);
        push_pass(120, 100, 0, 6, 5, 1'b0);
        start = 1'b1;
        wait_to(121);
        start = 1'b0;
        wait_to(137);
        reset = 1'b1;
        wait_to(138);
        chk("abort_inst", int'(inst), 0);
        chk("abort_mem_cen", int'(mem_cen), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        wait_to(142);
        push_pass(142, 100, 0, 8, 8, 1'b1);
        start = 1'b1;
        wait_to(143);
        start = 1'b0;
        wait_to(174);

        // start held high: two back-to-back passes, one IDLE cycle apart
        wait_to(180);
        push_pass(180, 100, 0, 8, 8, 1'b1);
        push_pass(210, 100, 0, 8, 8, 1'b1);
        start = 1'b1;
        wait_to(209);
        chk("b2b_fin_busy", int'(busy), 1);
        wait_to(210);
        chk("b2b_idle_busy", int'(busy), 0);
        wait_to(215);
        start = 1'b0;
        wait_to(245);

        chk("rdq_drained", int'(rdq.size()), 0);
        chk("instq_drained", int'(instq.size()), 0);
        chk("doneq_drained", int'(doneq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
